// File: rtl/test_align_pkg.sv
// Shared constants, helper function and types for the golden/DUT alignment stage.
package test_align_pkg;

  localparam int unsigned DefDwidth = 16;
  localparam int unsigned DefN      = 4;
  localparam int unsigned DefDepth  = 16;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Where the golden half of an emitted pair comes from this cycle.
  typedef enum logic [1:0] {
    PairNone   = 2'd0,
    PairFifo   = 2'd1,
    PairBypass = 2'd2
  } pair_src_e;

endpackage

// File: rtl/test_align_if.sv
// Golden/DUT input streams and aligned comparator-side outputs of test_align.
interface test_align_if #(
  parameter int unsigned DWIDTH = test_align_pkg::DefDwidth,
  parameter int unsigned N      = test_align_pkg::DefN,
  parameter int unsigned DEPTH  = test_align_pkg::DefDepth
);
  localparam int unsigned AW = test_align_pkg::clog2(DEPTH);
  localparam int unsigned VW = DWIDTH * N;

  logic          ref_valid;
  logic [VW-1:0] ref_data;
  logic          dut_valid;
  logic [VW-1:0] dut_data;
  logic [VW-1:0] d0;
  logic [VW-1:0] d1;
  logic          dvalid;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          underflow;
  logic [31:0]   pair_cnt;

  modport master (
    output ref_valid, ref_data, dut_valid, dut_data,
    input  d0, d1, dvalid, fifo_level, overflow, underflow, pair_cnt
  );

  modport slave (
    input  ref_valid, ref_data, dut_valid, dut_data,
    output d0, d1, dvalid, fifo_level, overflow, underflow, pair_cnt
  );

endinterface

// File: rtl/test_align_sync_fifo.sv
// Golden-vector FIFO: registered storage, wrapping pointers and a registered level count.
module test_align_sync_fifo
  import test_align_pkg::*;
#(
  parameter int unsigned WIDTH = DefDwidth * DefN,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [clog2(DEPTH):0] level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;

  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);
  assign level = level_q;
  // Head is read from registered storage so the pop and its data share a cycle.
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/test_align.sv
// Pairs each DUT result with the oldest pending golden vector for the downstream comparator.
module test_align
  import test_align_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned N      = DefN,
  parameter int unsigned DEPTH  = DefDepth
) (
  input logic         clk,
  input logic         rst,
  test_align_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned VW = DWIDTH * N;

  logic [VW-1:0] head;
  logic [AW:0]   level;
  logic          full, empty;
  logic          push, pop;
  logic          ovf_set, unf_set;
  pair_src_e     pair_src;
  logic [VW-1:0] golden;

  logic [VW-1:0] d0_q, d1_q;
  logic          dvalid_q;
  logic          overflow_q, underflow_q;
  logic [31:0]   pair_cnt_q;

  test_align_sync_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.ref_data),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pair_src = PairNone;
    pop      = 1'b0;
    push     = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (bus.dut_valid) begin
      if (!empty) begin
        pair_src = PairFifo;
        pop      = 1'b1;
      end else if (bus.ref_valid) begin
        pair_src = PairBypass;
      end else begin
        unf_set = 1'b1;
      end
    end
    // A bypassed golden vector is consumed directly and never stored.
    if (bus.ref_valid && (pair_src != PairBypass)) begin
      if (!full || pop) begin
        push = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_comb begin
    golden = '0;
    unique case (pair_src)
      PairFifo:   golden = head;
      PairBypass: golden = bus.ref_data;
      default:    golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q        <= '0;
      d1_q        <= '0;
      dvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      dvalid_q <= (pair_src != PairNone);
      if (pair_src != PairNone) begin
        d0_q       <= bus.dut_data;
        d1_q       <= golden;
        pair_cnt_q <= pair_cnt_q + 32'd1;
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
      if (unf_set) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.d0         = d0_q;
  assign bus.d1         = d1_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
  assign bus.pair_cnt   = pair_cnt_q;

endmodule

// File: tb/tb_test_align.sv
// Scoreboard bench for test_align: stimulus queues expected pairs, a negedge monitor checks them.
module tb_test_align;

  localparam int unsigned VW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  test_align_if bus ();

  test_align u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [VW-1:0] exp_d0_q[$];
  logic [VW-1:0] exp_d1_q[$];

  function automatic logic [VW-1:0] rep(input logic [15:0] w);
    return {4{w}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every dvalid pulse must match the oldest expected pair.
  always @(negedge clk) begin
    if (bus.dvalid === 1'b1) begin
      if (exp_d0_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dvalid: got d0=%h d1=%h, expected no pair", bus.d0, bus.d1);
      end else begin
        check("pair_d0", bus.d0, exp_d0_q.pop_front());
        check("pair_d1", bus.d1, exp_d1_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [VW-1:0] rd,
                       input logic dv, input logic [VW-1:0] dd);
    bus.ref_valid = rv;
    bus.ref_data  = rd;
    bus.dut_valid = dv;
    bus.dut_data  = dd;
    tick();
    bus.ref_valid = 1'b0;
    bus.dut_valid = 1'b0;
  endtask

  task automatic expect_pair(input logic [VW-1:0] e0, input logic [VW-1:0] e1);
    exp_d0_q.push_back(e0);
    exp_d1_q.push_back(e1);
    exp_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    bus.ref_valid = 1'b0;
    bus.dut_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    bus.ref_valid = 1'b0;
    bus.ref_data  = '0;
    bus.dut_valid = 1'b0;
    bus.dut_data  = '0;

    // 1: reset state, three buffered goldens then three DUT results
    do_reset(2);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_dvalid", 64'(bus.dvalid), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_underflow", 64'(bus.underflow), 64'd0);
    check("rst_pair_cnt", 64'(bus.pair_cnt), 64'd0);
    for (int k = 1; k <= 3; k++) drive(1'b1, rep(16'(k)), 1'b0, '0);
    for (int i = 0; i < 5; i++) tick();
    check("t1_level_3", 64'(bus.fifo_level), 64'd3);
    for (int k = 1; k <= 3; k++) begin
      expect_pair(rep(16'(16'hD000 + k)), rep(16'(k)));
      drive(1'b0, '0, 1'b1, rep(16'(16'hD000 + k)));
    end
    tick();
    check("t1_level_0", 64'(bus.fifo_level), 64'd0);
    check("t1_pair_cnt", 64'(bus.pair_cnt), 64'(exp_cnt));
    check("t1_overflow", 64'(bus.overflow), 64'd0);
    check("t1_underflow", 64'(bus.underflow), 64'd0);

    // 2: bypass when empty
    expect_pair(rep(16'hBBBB), rep(16'hAAAA));
    drive(1'b1, rep(16'hAAAA), 1'b1, rep(16'hBBBB));
    check("t2_dvalid", 64'(bus.dvalid), 64'd1);
    check("t2_level", 64'(bus.fifo_level), 64'd0);
    check("t2_pair_cnt", 64'(bus.pair_cnt), 64'd4);

    // 3: overfill by one, then drain; the dropped 0x3010 must never appear
    for (int i = 0; i < 16; i++) drive(1'b1, rep(16'(16'h3000 + i)), 1'b0, '0);
    check("t3_level_full", 64'(bus.fifo_level), 64'd16);
    check("t3_no_ovf_yet", 64'(bus.overflow), 64'd0);
    drive(1'b1, rep(16'h3010), 1'b0, '0);
    check("t3_level_held", 64'(bus.fifo_level), 64'd16);
    check("t3_overflow", 64'(bus.overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      expect_pair(rep(16'(16'hE000 + i)), rep(16'(16'h3000 + i)));
      drive(1'b0, '0, 1'b1, rep(16'(16'hE000 + i)));
    end
    tick();
    check("t3_drained", 64'(bus.fifo_level), 64'd0);

    // 4: full FIFO with simultaneous push and pop
    do_reset(1);
    for (int i = 0; i < 16; i++) drive(1'b1, rep(16'(16'h6000 + i)), 1'b0, '0);
    check("t4_level_full", 64'(bus.fifo_level), 64'd16);
    for (int i = 0; i < 4; i++) begin
      expect_pair(rep(16'(16'h5000 + i)), rep(16'(16'h6000 + i)));
      drive(1'b1, rep(16'(16'h4000 + i)), 1'b1, rep(16'(16'h5000 + i)));
      check("t4_level_steady", 64'(bus.fifo_level), 64'd16);
    end
    check("t4_overflow", 64'(bus.overflow), 64'd0);
    check("t4_pair_cnt", 64'(bus.pair_cnt), 64'd4);
    for (int i = 0; i < 16; i++) begin
      if (i < 12) expect_pair(rep(16'(16'hF000 + i)), rep(16'(16'h6004 + i)));
      else        expect_pair(rep(16'(16'hF000 + i)), rep(16'(16'h4000 + i - 12)));
      drive(1'b0, '0, 1'b1, rep(16'(16'hF000 + i)));
    end
    tick();
    check("t4_drained", 64'(bus.fifo_level), 64'd0);

    // 5: underflow
    check("t5_unf_clear", 64'(bus.underflow), 64'd0);
    drive(1'b0, '0, 1'b1, rep(16'hDEAD));
    check("t5_no_dvalid", 64'(bus.dvalid), 64'd0);
    check("t5_underflow", 64'(bus.underflow), 64'd1);
    check("t5_pair_cnt", 64'(bus.pair_cnt), 64'(exp_cnt));
    tick();
    tick();
    check("t5_unf_sticky", 64'(bus.underflow), 64'd1);

    // 6: reset mid-stream flushes pending goldens
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(1'b1, rep(16'(16'h7000 + i)), 1'b0, '0);
    check("t6_level_5", 64'(bus.fifo_level), 64'd5);
    do_reset(1);
    check("t6_level_flushed", 64'(bus.fifo_level), 64'd0);
    check("t6_pair_cnt", 64'(bus.pair_cnt), 64'd0);
    drive(1'b0, '0, 1'b1, rep(16'h1234));
    check("t6_no_dvalid", 64'(bus.dvalid), 64'd0);
    check("t6_underflow", 64'(bus.underflow), 64'd1);
    check("t6_level", 64'(bus.fifo_level), 64'd0);

    for (int i = 0; i < 20 && exp_d0_q.size() != 0; i++) tick();
    tick();
    check("queue_drained", 64'(exp_d0_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
